sp_adder_issue_ctrl: RTL and testbench
======================================

Name: sp_adder_issue_ctrl

Overview:
- Sits directly upstream and downstream of the 16-bit unsigned Xilinx pipelined adder wrapper, which has a clock enable, a fixed latency of 2 and no backpressure.
- Accepts operand pairs on a valid/ready stream and drives the adder's CE/A/B.
- Tracks each in-flight item with its own tag pipeline and captures each S into a result FIFO.
- Presents results on a valid/ready stream and stalls the adder via CE when the FIFO cannot absorb a result.

Parameters:
- W, 16, operand/result width; must match the adder.
- LAT, 2, adder latency in CE-enabled cycles; must be ≥1.
- DEPTH, 4, result FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts a pair this cycle
- in_a  in  W  operand A
- in_b  in  W  operand B
- add_ce  out  1  adder clock enable
- add_a  out  W  adder A
- add_b  out  W  adder B
- add_s  in  W  adder sum
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_s  out  W  result (FIFO head)
- fifo_count  out  log2(DEPTH)+1  result FIFO occupancy
- inflight  out  log2(LAT)+1  number of tagged items inside the adder pipeline

Behaviour:
- Reset (resetn=0 at a clk edge):
  - Clears the tag shift register, FIFO pointers and count.
  - Outputs during and after reset: add_ce=0, in_ready=0, out_valid=0, fifo_count=0, inflight=0.
  - Adder contents at reset are untagged and are discarded.
- Tag pipeline:
  - tag[0..LAT-1] shifts by one position only when add_ce=1.
  - tag[0] is loaded with (in_valid && in_ready).
  - tag_out = tag[LAT-1]; this bit marks that add_s holds a real sum.
  - add_s is held stable by the adder while add_ce=0.
- CE rule (combinational): add_ce = resetn_q && !(tag_out && fifo_full && !pop).
  - resetn_q is a register that is 0 in reset and 1 afterwards.
  - add_ce stays high during bubbles so the pipeline drains.
- Input:
  - in_ready = add_ce.
  - add_a = in_a and add_b = in_b, combinational passthrough.
  - A pair transfers on in_valid && in_ready.
  - in_valid with in_ready=0 must be held by the source (standard valid/ready).
- Push: push = add_ce && tag_out; writes add_s to the FIFO tail.
- Pop: pop = out_valid && out_ready.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged and no stall occurs.
- FIFO:
  - out_valid = (count != 0).
  - out_s is the head entry, registered storage.
  - Pointers wrap modulo DEPTH.
  - Push when full cannot occur by construction; assert in simulation.
- Latency: a pair accepted at edge t with add_ce continuously 1 is pushed at edge t+LAT, and out_valid rises in the cycle after that edge.
- Throughput: 1 result/cycle while out_ready=1.
- Arithmetic: sums wrap modulo 2^W inside the adder; the block does not add or check carry.
- The adder wrapper's own valid output is NOT used. It resets on any CE gap, while tagged data remains legitimate.
- inflight = popcount(tag).
- Reset mid-operation: in-flight tags and FIFO contents are dropped; no output appears for them after reset release.

Test Plan:
- Single op after reset: in_a=0x0003, in_b=0x0004, out_ready=1 -> out_valid high 1 cycle with out_s=0x0007; inflight returns to 0.
- Wrap-around: 0xFFFF+0x0002 -> out_s=0x0001.
- Back-to-back stream: 8 pairs (i, 2i), i=0..7, in_valid=1 continuously, out_ready=1 -> in_ready never drops; results 3i in order with no gaps after the first arrives.
- Backpressure, out_ready=0:
  - Stream 8 pairs -> FIFO fills to 4 and in_ready/add_ce drop once tag_out is set and the FIFO is full; exactly DEPTH+LAT=6 pairs are accepted.
  - Then out_ready=1 -> all 6 results emerge in order with correct values; no loss or duplication.
- Simultaneous push/pop on a full FIFO:
  - Precondition: count=4 with tag_out=1.
  - out_ready=1 -> add_ce stays 1, count stays 4, ordering preserved.
- Reset mid-stream: resetn=0 for 1 cycle with 2 items in flight and 3 in the FIFO -> out_valid=0, fifo_count=0, inflight=0 next cycle; subsequent 0x0010+0x0020 gives a single result 0x0030.

Source files
------------

// File: rtl/sp_adder_issue_ctrl.sv
// Issue/retire controller around a fixed-latency pipelined adder with clock enable.
// Tags each issued pair through the adder, captures sums into a result FIFO, and stalls the adder via CE on backpressure.
module sp_adder_issue_ctrl #(
  parameter int W     = 16,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_a,
  input  logic [W-1:0]               in_b,
  output logic                       add_ce,
  output logic [W-1:0]               add_a,
  output logic [W-1:0]               add_b,
  input  logic [W-1:0]               add_s,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_s,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [$clog2(LAT):0]       inflight
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(LAT) + 1;

  logic            resetn_q;
  logic [LAT-1:0]  tag_q, tag_d;
  logic            tag_out;
  logic            in_fire;
  logic            push, pop;
  logic            fifo_full;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic [IW-1:0]   inflight_d;

  always_ff @(posedge clk) begin
    resetn_q <= resetn;
  end

  assign tag_out   = tag_q[LAT-1];
  assign fifo_full = (count_q == CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  // Only stall when a real sum is about to land in a FIFO that nobody is draining.
  assign add_ce    = resetn_q && !(tag_out && fifo_full && !pop);
  assign in_ready  = add_ce;
  assign in_fire   = in_valid && in_ready;
  assign push      = add_ce && tag_out;

  assign add_a = in_a;
  assign add_b = in_b;

  // Tag pipeline mirrors the adder stages and advances only with CE.
  assign tag_d[0] = add_ce ? in_fire : tag_q[0];
  for (genvar gi = 1; gi < LAT; gi++) begin : g_tag
    assign tag_d[gi] = add_ce ? tag_q[gi-1] : tag_q[gi];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      assert (!(push && fifo_full && !pop));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= add_s;
    end
  end

  assign out_s      = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  always_comb begin
    inflight_d = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight_d = inflight_d + IW'(tag_q[i]);
    end
  end

  assign inflight = inflight_d;

endmodule

// File: tb/tb_sp_adder_issue_ctrl.sv
// Directed bench for sp_adder_issue_ctrl with a behavioural 2-stage CE adder model.
module tb_sp_adder_issue_ctrl;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        add_ce;
  logic [15:0] add_a, add_b, add_s;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_s;
  logic [2:0]  fifo_count;
  logic [1:0]  inflight;

  sp_adder_issue_ctrl #(.W(16), .LAT(2), .DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_ce(add_ce), .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .fifo_count(fifo_count), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder model: two CE-gated stages, output held while CE is low.
  logic [15:0] p0, p1;
  always @(posedge clk) begin
    if (add_ce === 1'b1) begin
      p0 <= add_a + add_b;
      p1 <= p0;
    end
  end
  assign add_s = p1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt;
  int stall_cnt;
  logic [15:0] res_q[$];
  int          res_cyc[$];
  logic [15:0] src_a[$];
  logic [15:0] src_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      res_q.push_back(out_s);
      res_cyc.push_back(cyc);
      $display("result %04h at cycle %0d", out_s, cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents src_a/src_b in order for ncycles cycles, advancing on each transfer.
  task automatic stream(input int ncycles);
    int idx;
    logic fire;
    idx = 0;
    acc_cnt = 0;
    stall_cnt = 0;
    for (int c = 0; c < ncycles; c++) begin
      if (idx < src_a.size()) begin
        in_valid = 1'b1;
        in_a = src_a[idx];
        in_b = src_b[idx];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      fire = in_valid && in_ready;
      if (in_valid && !in_ready) stall_cnt++;
      @(posedge clk);
      #1;
      if (fire) begin
        idx++;
        acc_cnt++;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    // Reset state
    tick(2);
    check("rst_add_ce", 32'(add_ce), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_inflight", 32'(inflight), 0);
    resetn = 1'b1;
    tick(1);
    check("idle_add_ce", 32'(add_ce), 1);

    // Single op, latency check
    res_q.delete();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'h0003; in_b = 16'h0004;
    tick(1);
    in_valid = 1'b0;
    check("single_inflight_a", 32'(inflight), 1);
    check("single_early_valid", 32'(out_valid), 0);
    tick(1);
    check("single_inflight_b", 32'(inflight), 1);
    check("single_valid_pre", 32'(out_valid), 0);
    tick(1);
    check("single_valid", 32'(out_valid), 1);
    check("single_sum", 32'(out_s), 32'h7);
    check("single_count", 32'(fifo_count), 1);
    check("single_inflight_c", 32'(inflight), 0);
    tick(1);
    check("single_valid_drop", 32'(out_valid), 0);
    check("single_count_drop", 32'(fifo_count), 0);
    check("single_nres", res_q.size(), 1);

    // Wrap-around
    res_q.delete();
    src_a = '{16'hFFFF}; src_b = '{16'h0002};
    stream(1);
    tick(4);
    check("wrap_nres", res_q.size(), 1);
    if (res_q.size() > 0) check("wrap_sum", 32'(res_q[0]), 32'h0001);

    // Back-to-back stream of (i, 2i)
    res_q.delete(); res_cyc.delete();
    src_a = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    src_b = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12, 16'd14};
    stream(10);
    tick(4);
    check("b2b_accepted", acc_cnt, 8);
    check("b2b_stalls", stall_cnt, 0);
    check("b2b_nres", res_q.size(), 8);
    if (res_q.size() == 8) begin
      check("b2b_r0", 32'(res_q[0]), 32'd0);
      check("b2b_r1", 32'(res_q[1]), 32'd3);
      check("b2b_r2", 32'(res_q[2]), 32'd6);
      check("b2b_r3", 32'(res_q[3]), 32'd9);
      check("b2b_r4", 32'(res_q[4]), 32'd12);
      check("b2b_r5", 32'(res_q[5]), 32'd15);
      check("b2b_r6", 32'(res_q[6]), 32'd18);
      check("b2b_r7", 32'(res_q[7]), 32'd21);
      check("b2b_nogap", res_cyc[7] - res_cyc[0], 7);
    end

    // Backpressure: 8 offered, DEPTH+LAT accepted
    res_q.delete();
    out_ready = 1'b0;
    src_a = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h0107};
    src_b = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
    stream(12);
    check("bp_accepted", acc_cnt, 6);
    check("bp_count", 32'(fifo_count), 4);
    check("bp_inflight", 32'(inflight), 2);
    check("bp_add_ce", 32'(add_ce), 0);
    check("bp_in_ready", 32'(in_ready), 0);

    // Full FIFO with tag_out set: push and pop together
    out_ready = 1'b1;
    @(negedge clk);
    check("pp_add_ce", 32'(add_ce), 1);
    check("pp_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    check("pp_count", 32'(fifo_count), 4);
    check("pp_inflight", 32'(inflight), 1);
    tick(8);
    check("bp_nres", res_q.size(), 6);
    if (res_q.size() == 6) begin
      check("bp_r0", 32'(res_q[0]), 32'h0100);
      check("bp_r1", 32'(res_q[1]), 32'h0102);
      check("bp_r2", 32'(res_q[2]), 32'h0104);
      check("bp_r3", 32'(res_q[3]), 32'h0106);
      check("bp_r4", 32'(res_q[4]), 32'h0108);
      check("bp_r5", 32'(res_q[5]), 32'h010A);
    end
    check("bp_drained", 32'(fifo_count), 0);
    check("bp_inflight_end", 32'(inflight), 0);

    // Reset mid-stream: 3 in FIFO, 2 in flight
    res_q.delete();
    out_ready = 1'b0;
    src_a = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    src_b = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    stream(5);
    check("mr_pre_count", 32'(fifo_count), 3);
    check("mr_pre_inflight", 32'(inflight), 2);
    resetn = 1'b0;
    tick(1);
    check("mr_out_valid", 32'(out_valid), 0);
    check("mr_count", 32'(fifo_count), 0);
    check("mr_inflight", 32'(inflight), 0);
    check("mr_add_ce", 32'(add_ce), 0);
    resetn = 1'b1;
    out_ready = 1'b1;
    tick(1);
    src_a = '{16'h0010}; src_b = '{16'h0020};
    stream(1);
    tick(5);
    check("mr_nres", res_q.size(), 1);
    if (res_q.size() > 0) check("mr_sum", 32'(res_q[0]), 32'h0030);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
